serial_adder_controller: RTL and testbench

Bit-serial N-bit adder built around the team's single `full_adder` cell. It accepts two WIDTH-bit operands and a carry-in through a start/done handshake. It then sequences the one full adder over WIDTH clock cycles, LSB first, with a carry flip-flop closing the loop. It sits where area matters more than latency, and it is the first sequential block layered on the atomic adder.

---
 rtl/serial_adder_controller.sv | 170 +++++++++++++++++
 tb/tb_serial_adder_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_controller.sv
// ---------------------------------------------------------------------------
// serial_adder_controller
//
// Bit-serial WIDTH-bit adder. A single full_adder cell is sequenced over
// WIDTH clock cycles, LSB first, and a carry flip-flop closes the loop.
// Operands and the carry-in are captured when start is accepted in IDLE.
//
// Handshake: start is level-sampled and is only looked at in IDLE. A high
// start on an IDLE edge is the accept. busy is high for the WIDTH RUN cycles.
// done is a single-cycle pulse in DONE, and sum/carry_out are valid from that
// cycle until the first RUN edge of the next operation. busy and done are
// decoded from the state register only, so they never depend on the inputs
// combinationally and are never high together.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous reset, active-low
//   start      in   operation request (sampled in IDLE only)
//   augend     in   [WIDTH-1:0] first operand
//   addend     in   [WIDTH-1:0] second operand
//   carry_in   in   carry into bit 0
//   busy       out  high while in RUN
//   done       out  one-cycle completion pulse (DONE state)
//   sum        out  [WIDTH-1:0] result bits
//   carry_out  out  result bit WIDTH
//   state_dbg  out  [1:0] FSM state: 0 = IDLE, 1 = RUN, 2 = DONE
// ---------------------------------------------------------------------------

// Single-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_sum;
  logic fa_carry;
  logic last_bit;

  // The one and only adder cell on the operand path.
  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (c_q),
    .s_o (fa_sum),
    .c_o (fa_carry)
  );

  // Counter holds the index of the bit being processed this RUN cycle.
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    state_dbg = state_q;
  end

  // ---------------- Datapath next-state ----------------
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    c_d   = c_q;
    co_d  = co_q;
    cnt_d = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d   = augend;
          b_d   = addend;
          c_d   = carry_in;
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        // Sum bits enter at the top so that after WIDTH shifts bit 0 sits at
        // s_q[0]. Operands shift down, zero-filled, to present the next bit.
        s_d   = {fa_sum, s_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = fa_carry;
        cnt_d = cnt_q + CW'(1);
        // carry_out keeps the previous result until the final bit.
        if (last_bit) co_d = fa_carry;
      end
      default: ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      co_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      co_q  <= co_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum       = s_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_serial_adder_controller.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_controller
//
// Self-checking bench for serial_adder_controller. A WIDTH=8 instance covers
// reset, table vectors, handshake, mid-operation reset and 500 random
// back-to-back operations. A WIDTH=2 instance is checked exhaustively.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_adder_controller;

  localparam int W  = 8;
  localparam int W2 = 2;

  // ---------------- clock/reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n  = 1'b0;
  logic reset_n2 = 1'b0;

  // ---------------- WIDTH=8 DUT ----------------
  logic         start    = 1'b0;
  logic [W-1:0] augend   = '0;
  logic [W-1:0] addend   = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  serial_adder_controller #(.WIDTH(W)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .augend    (augend),
    .addend    (addend),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .state_dbg (state_dbg)
  );

  // ---------------- WIDTH=2 DUT ----------------
  logic          start2 = 1'b0;
  logic [W2-1:0] aug2   = '0;
  logic [W2-1:0] add2   = '0;
  logic          cin2   = 1'b0;
  logic          busy2, done2, co2;
  logic [W2-1:0] sum2;
  logic [1:0]    state_dbg2;

  serial_adder_controller #(.WIDTH(W2)) u_dut2 (
    .clock     (clock),
    .reset_n   (reset_n2),
    .start     (start2),
    .augend    (aug2),
    .addend    (add2),
    .carry_in  (cin2),
    .busy      (busy2),
    .done      (done2),
    .sum       (sum2),
    .carry_out (co2),
    .state_dbg (state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic rnd_en = 1'b0;
  int   rnd_done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Random phase: every done pops the oldest expected result.
  always @(negedge clock) begin
    if (rnd_en && done) begin
      if (exp_q.size() == 0) begin
        chk("rnd_spurious_done", 1, 0);
      end else begin
        chk("rnd_result", {carry_out, sum}, exp_q.pop_front());
        rnd_done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called with the DUT idle, 1 unit after a rising edge. Returns likewise.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W:0] exp, input string nm);
    int n;
    int nb;
    bit seen;
    augend = a; addend = b; carry_in = c; start = 1'b1;
    @(posedge clock); #1;          // start edge E0
    start = 1'b0;
    augend = W'($urandom); addend = W'($urandom); carry_in = 1'($urandom);
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clock);
      n++;
      if (busy) nb++;
      chk({nm, "_busy_done_overlap"}, busy & done, 0);
      seen = done;
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_latency"}, n, W + 1);
    chk({nm, "_busy_cycles"}, nb, W);
    chk({nm, "_result"}, {carry_out, sum}, exp);
    @(posedge clock); #1;
    chk({nm, "_done_cleared"}, {busy, done}, 0);
  endtask

  task automatic run_op2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c);
    int n;
    int nb;
    bit seen;
    logic [W2:0] exp;
    string nm;
    nm  = $sformatf("w2_%0d_%0d_%0d", a, b, c);
    exp = {1'b0, a} + {1'b0, b} + (W2+1)'(c);
    aug2 = a; add2 = b; cin2 = c; start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0; aug2 = ~a; add2 = ~b; cin2 = ~c;
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (busy2) nb++;
      seen = done2;
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_latency"}, n, W2 + 1);
    chk({nm, "_busy_cycles"}, nb, W2);
    chk({nm, "_result"}, {co2, sum2}, exp);
    @(posedge clock); #1;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    int t1;
    int t2;
    int pushed;
    int gap;

    tbl[0] = '{8'h35, 8'h4A, 1'b0, 9'h07F};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 9'h001};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
    tbl[5] = '{8'h5A, 8'hA5, 1'b1, 9'h100};

    // Reset held for 3 cycles, then released with start low.
    repeat (3) begin
      @(negedge clock);
      chk("rst_hold", {busy, done, carry_out, sum}, 0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1; reset_n2 = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("rst_idle", {busy, done, carry_out, sum}, 0);
    end
    chk("rst_state", state_dbg, 0);
    chk("rst_state_w2", state_dbg2, 0);
    chk("rst_idle_w2", {busy2, done2, co2, sum2}, 0);
    @(posedge clock); #1;

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Handshake: start held high, operands changing during RUN.
    augend = 8'h10; addend = 8'h20; carry_in = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    n = 0; t1 = 0; t2 = 0;
    while (t2 == 0 && n < 40) begin
      augend = 8'hAA; addend = 8'h55; carry_in = 1'b0;
      @(negedge clock);
      n++;
      if (done) begin
        if (t1 == 0) begin
          t1 = n;
          chk("hs_first_result", {carry_out, sum}, 9'h030);
        end else begin
          t2 = n;
          start = 1'b0;
          chk("hs_second_result", {carry_out, sum}, 9'h0FF);
        end
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    chk("hs_first_latency", t1, W + 1);
    chk("hs_done_spacing", t2 - t1, W + 2);

    // Asynchronous reset between RUN edges E3 and E4.
    augend = 8'hC3; addend = 8'h5A; carry_in = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, done, carry_out, sum}, 0);
    repeat (3) begin
      @(negedge clock);
      chk("midrst_held", {busy, done, carry_out, sum}, 0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clock);
      chk("midrst_no_done", done, 0);
    end
    @(posedge clock); #1;
    run_op(8'h12, 8'h34, 1'b1, 9'h047, "post_reset");

    // Random back-to-back operations against the arithmetic model.
    // With start held high an operation is accepted every W+2 edges.
    rnd_en = 1'b1;
    pushed = 0;
    gap = 0;
    while (pushed < 500) begin
      start = 1'b1;
      augend = W'($urandom); addend = W'($urandom); carry_in = 1'($urandom_range(0, 1));
      if (gap == 0) begin
        exp_q.push_back({1'b0, augend} + {1'b0, addend} + (W+1)'(carry_in));
        pushed++;
        gap = W + 1;
      end else begin
        gap--;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_count", rnd_done_cnt, 500);
    rnd_en = 1'b0;
    @(posedge clock); #1;

    // Exhaustive WIDTH=2.
    for (int i = 0; i < 32; i++) begin
      run_op2(W2'(i >> 3), W2'(i >> 1), i[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
